// File: rtl/axil_cmd_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axil_cmd_arbiter: round-robin 2-requester command arbiter, AXI4-Lite mst |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module axil_cmd_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3
) (
  input  logic                    s3_axi_aclk,
  input  logic                    s3_axi_aresetn,

  input  logic                    req0_valid,
  input  logic                    req0_write,
  input  logic [ADDR_WIDTH-1:0]   req0_addr,
  input  logic [DATA_WIDTH-1:0]   req0_wdata,
  input  logic [DATA_WIDTH/8-1:0] req0_wstrb,
  output logic                    req0_ready,
  output logic                    resp0_valid,
  output logic [DATA_WIDTH-1:0]   resp0_rdata,
  output logic [RESP_WIDTH-1:0]   resp0_resp,

  input  logic                    req1_valid,
  input  logic                    req1_write,
  input  logic [ADDR_WIDTH-1:0]   req1_addr,
  input  logic [DATA_WIDTH-1:0]   req1_wdata,
  input  logic [DATA_WIDTH/8-1:0] req1_wstrb,
  output logic                    req1_ready,
  output logic                    resp1_valid,
  output logic [DATA_WIDTH-1:0]   resp1_rdata,
  output logic [RESP_WIDTH-1:0]   resp1_resp,

  output logic [ADDR_WIDTH-1:0]   m3_axi_awaddr,
  output logic                    m3_axi_awvalid,
  input  logic                    m3_axi_awready,
  output logic [DATA_WIDTH-1:0]   m3_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m3_axi_wstrb,
  output logic                    m3_axi_wvalid,
  input  logic                    m3_axi_wready,
  input  logic [RESP_WIDTH-1:0]   m3_axi_bresp,
  input  logic                    m3_axi_bvalid,
  output logic                    m3_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m3_axi_araddr,
  output logic                    m3_axi_arvalid,
  input  logic                    m3_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m3_axi_rdata,
  input  logic [RESP_WIDTH-1:0]   m3_axi_rresp,
  input  logic                    m3_axi_rvalid,
  output logic                    m3_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_WR_AW_W = 3'd2,
    S_WR_B    = 3'd3,
    S_RD_AR   = 3'd4,
    S_RD_R    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic                    gnt_q, gnt_d;
  logic                    last_grant_q, last_grant_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic                    req0_ready_q, req0_ready_d;
  logic                    req1_ready_q, req1_ready_d;
  logic                    resp0_valid_q, resp0_valid_d;
  logic                    resp1_valid_q, resp1_valid_d;
  logic [DATA_WIDTH-1:0]   resp0_rdata_q, resp0_rdata_d;
  logic [DATA_WIDTH-1:0]   resp1_rdata_q, resp1_rdata_d;
  logic [RESP_WIDTH-1:0]   resp0_resp_q, resp0_resp_d;
  logic [RESP_WIDTH-1:0]   resp1_resp_q, resp1_resp_d;

  logic                    pick1;
  logic                    aw_hs;
  logic                    w_hs;
  logic                    done_entry;
  logic [DATA_WIDTH-1:0]   done_rdata;
  logic [RESP_WIDTH-1:0]   done_resp;

  assign aw_hs = awvalid_q & m3_axi_awready;
  assign w_hs  = wvalid_q & m3_axi_wready;

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_grant_d  = last_grant_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    req0_ready_d  = 1'b0;
    req1_ready_d  = 1'b0;
    resp0_valid_d = 1'b0;
    resp1_valid_d = 1'b0;
    resp0_rdata_d = '0;
    resp1_rdata_d = '0;
    resp0_resp_d  = '0;
    resp1_resp_d  = '0;
    pick1         = 1'b0;
    done_entry    = 1'b0;
    done_rdata    = '0;
    done_resp     = '0;

    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          // On a tie the requester that did not win last time takes the grant.
          pick1        = req1_valid && (!req0_valid || !last_grant_q);
          gnt_d        = pick1;
          last_grant_d = pick1;
          write_d      = pick1 ? req1_write : req0_write;
          addr_d       = pick1 ? req1_addr  : req0_addr;
          wdata_d      = pick1 ? req1_wdata : req0_wdata;
          wstrb_d      = pick1 ? req1_wstrb : req0_wstrb;
          req0_ready_d = !pick1;
          req1_ready_d = pick1;
          state_d      = S_GRANT;
        end
      end
      S_GRANT: begin
        if (write_q) begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WR_AW_W;
        end else begin
          arvalid_d = 1'b1;
          state_d   = S_RD_AR;
        end
      end
      S_WR_AW_W: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = S_WR_B;
        end
      end
      S_WR_B: begin
        if (m3_axi_bvalid) begin
          bready_d   = 1'b0;
          done_entry = 1'b1;
          done_resp  = m3_axi_bresp;
          state_d    = S_DONE;
        end
      end
      S_RD_AR: begin
        if (m3_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_R;
        end
      end
      S_RD_R: begin
        if (m3_axi_rvalid) begin
          rready_d   = 1'b0;
          done_entry = 1'b1;
          done_rdata = m3_axi_rdata;
          done_resp  = m3_axi_rresp;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Response registers are loaded only for the granted side, so the other side reads 0.
    if (done_entry) begin
      if (gnt_q) begin
        resp1_valid_d = 1'b1;
        resp1_rdata_d = done_rdata;
        resp1_resp_d  = done_resp;
      end else begin
        resp0_valid_d = 1'b1;
        resp0_rdata_d = done_rdata;
        resp0_resp_d  = done_resp;
      end
    end
  end

  always_ff @(posedge s3_axi_aclk or negedge s3_axi_aresetn) begin
    if (!s3_axi_aresetn) begin
      state_q       <= S_IDLE;
      gnt_q         <= 1'b0;
      last_grant_q  <= 1'b1;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      req0_ready_q  <= 1'b0;
      req1_ready_q  <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_rdata_q <= '0;
      resp1_rdata_q <= '0;
      resp0_resp_q  <= '0;
      resp1_resp_q  <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      last_grant_q  <= last_grant_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      req0_ready_q  <= req0_ready_d;
      req1_ready_q  <= req1_ready_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp0_rdata_q <= resp0_rdata_d;
      resp1_rdata_q <= resp1_rdata_d;
      resp0_resp_q  <= resp0_resp_d;
      resp1_resp_q  <= resp1_resp_d;
    end
  end

  assign req0_ready     = req0_ready_q;
  assign req1_ready     = req1_ready_q;
  assign resp0_valid    = resp0_valid_q;
  assign resp1_valid    = resp1_valid_q;
  assign resp0_rdata    = resp0_rdata_q;
  assign resp1_rdata    = resp1_rdata_q;
  assign resp0_resp     = resp0_resp_q;
  assign resp1_resp     = resp1_resp_q;

  // The latched command drives both address channels; only one valid is ever raised.
  assign m3_axi_awaddr  = addr_q;
  assign m3_axi_araddr  = addr_q;
  assign m3_axi_wdata   = wdata_q;
  assign m3_axi_wstrb   = wstrb_q;
  assign m3_axi_awvalid = awvalid_q;
  assign m3_axi_wvalid  = wvalid_q;
  assign m3_axi_bready  = bready_q;
  assign m3_axi_arvalid = arvalid_q;
  assign m3_axi_rready  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_cmd_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axil_cmd_arbiter: directed self-checking bench for axil_cmd_arbiter   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_axil_cmd_arbiter;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int RW = 3;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          req0_valid, req0_write, req0_ready, resp0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, resp0_rdata;
  logic [SW-1:0] req0_wstrb;
  logic [RW-1:0] resp0_resp;
  logic          req1_valid, req1_write, req1_ready, resp1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, resp1_rdata;
  logic [SW-1:0] req1_wstrb;
  logic [RW-1:0] resp1_resp;

  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, r_data;
  logic [SW-1:0] wstrb;
  logic [RW-1:0] b_resp, r_resp;

  axil_cmd_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) dut (
    .s3_axi_aclk(clk), .s3_axi_aresetn(rst_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb), .req0_ready(req0_ready),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_resp(resp0_resp),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb), .req1_ready(req1_ready),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_resp(resp1_resp),
    .m3_axi_awaddr(awaddr), .m3_axi_awvalid(awvalid), .m3_axi_awready(awready),
    .m3_axi_wdata(wdata), .m3_axi_wstrb(wstrb), .m3_axi_wvalid(wvalid),
    .m3_axi_wready(wready), .m3_axi_bresp(b_resp), .m3_axi_bvalid(bvalid),
    .m3_axi_bready(bready), .m3_axi_araddr(araddr), .m3_axi_arvalid(arvalid),
    .m3_axi_arready(arready), .m3_axi_rdata(r_data), .m3_axi_rresp(r_resp),
    .m3_axi_rvalid(rvalid), .m3_axi_rready(rready)
  );

  int total = 0;
  int bad   = 0;

  int aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int bhs = 0;
  bit b_hs_next = 1'b0;

  int gq[$];
  int dual = 0, r0cnt = 0, r1cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Slave model: each ready rises after its programmed number of wait cycles.
  initial begin
    awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
    forever begin
      @(negedge clk);
      if (b_hs_next) bhs++;
      if (awvalid) begin awready = (aw_cnt == aw_lat); aw_cnt++; end
      else begin awready = 1'b0; aw_cnt = 0; end
      if (wvalid) begin wready = (w_cnt == w_lat); w_cnt++; end
      else begin wready = 1'b0; w_cnt = 0; end
      if (arvalid) begin arready = (ar_cnt == ar_lat); ar_cnt++; end
      else begin arready = 1'b0; ar_cnt = 0; end
      bvalid = bready;
      b_hs_next = bvalid && bready;
      if (rready) begin rvalid = (r_cnt == r_lat); r_cnt++; end
      else begin rvalid = 1'b0; r_cnt = 0; end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (req0_ready) gq.push_back(0);
      if (req1_ready) gq.push_back(1);
      if (req0_ready && req1_ready) dual++;
      if (resp0_valid) r0cnt++;
      if (resp1_valid) r1cnt++;
    end
  end

  initial begin
    int base0, base1, baseb;
    bit found;
    rst_n = 1'b0;
    req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0; req0_wstrb = '0;
    req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0; req1_wstrb = '0;
    b_resp = '0; r_data = '0; r_resp = '0;

    step(2);
    chk("rst_ctrl", {awvalid, wvalid, bready, arvalid, rready, req0_ready, req1_ready,
                     resp0_valid, resp1_valid}, 64'h0);
    chk("rst_addr", {awaddr, araddr, wstrb}, 64'h0);
    chk("rst_wdata", wdata, 64'h0);
    chk("rst_resp", {resp0_resp, resp1_resp, resp0_rdata}, 64'h0);
    rst_n = 1'b1;
    step(2);

    // Zero-wait write from requester 0
    b_resp = 3'b010;
    base0 = r0cnt;
    req0_valid = 1; req0_write = 1; req0_addr = 8'h00; req0_wdata = 32'd25; req0_wstrb = 4'hF;
    step(1);
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    req0_valid = 0;
    step(1);
    chk("t1_awwvalid", {awvalid, wvalid}, 2'b11);
    chk("t1_awaddr", awaddr, 8'h00);
    chk("t1_wdata", wdata, 32'd25);
    chk("t1_wstrb", wstrb, 4'hF);
    chk("t1_arvalid", arvalid, 0);
    step(1);
    chk("t1_bphase", {awvalid, wvalid, bready}, 3'b001);
    chk("t1_resp_early", resp0_valid, 0);
    // Accepting edge closed the cycle before the ready pulse: response 4 cycles on.
    step(1);
    chk("t1_resp_valid", resp0_valid, 1);
    chk("t1_resp_code", resp0_resp, 3'b010);
    chk("t1_resp_rdata", resp0_rdata, 0);
    chk("t1_resp1_quiet", {resp1_valid, resp1_rdata, resp1_resp}, 0);
    step(1);
    chk("t1_pulse_end", resp0_valid, 0);
    step(3);
    chk("t1_pulse_count", r0cnt - base0, 1);

    // Read from requester 1 with three AR wait cycles
    r_data = 32'h22; r_resp = 3'b000; ar_lat = 3;
    base1 = r1cnt;
    req1_valid = 1; req1_write = 0; req1_addr = 8'h08;
    step(1);
    chk("t2_ready1", req1_ready, 1);
    chk("t2_ready0", req0_ready, 0);
    req1_valid = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("t2_arvalid_hold", {arvalid, rready}, 2'b10);
      chk("t2_araddr_hold", araddr, 8'h08);
    end
    step(1);
    chk("t2_rphase", {arvalid, rready, awvalid, wvalid}, 4'b0100);
    step(1);
    chk("t2_resp_valid", resp1_valid, 1);
    chk("t2_rdata", resp1_rdata, 32'h22);
    chk("t2_rresp", resp1_resp, 0);
    chk("t2_resp0_quiet", resp0_valid, 0);
    step(3);
    chk("t2_pulse_count", r1cnt - base1, 1);
    ar_lat = 0;

    // Write where AW is accepted two cycles before W
    w_lat = 2; b_resp = 3'b011;
    base0 = r0cnt; baseb = bhs;
    req0_valid = 1; req0_write = 1; req0_addr = 8'h0C; req0_wdata = 32'hDEADBEEF; req0_wstrb = 4'h3;
    step(1);
    chk("t3_ready0", req0_ready, 1);
    req0_valid = 0;
    step(1);
    chk("t3_both_valid", {awvalid, wvalid}, 2'b11);
    step(1);
    chk("t3_aw_dropped", {awvalid, wvalid}, 2'b01);
    chk("t3_wdata_hold", {wdata, wstrb}, {32'hDEADBEEF, 4'h3});
    step(1);
    chk("t3_w_held", {awvalid, wvalid, bready}, 3'b010);
    step(1);
    chk("t3_bphase", {awvalid, wvalid, bready}, 3'b001);
    step(1);
    chk("t3_resp_valid", resp0_valid, 1);
    chk("t3_resp_code", resp0_resp, 3'b011);
    step(3);
    chk("t3_b_handshakes", bhs - baseb, 1);
    chk("t3_pulse_count", r0cnt - base0, 1);
    w_lat = 0;

    // Both requesters held valid from reset release: grants alternate
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    gq.delete();
    dual = 0;
    req0_valid = 1; req0_write = 0; req0_addr = 8'h10;
    req1_valid = 1; req1_write = 0; req1_addr = 8'h14;
    r_data = 32'h1234; r_resp = 3'b000;
    for (int i = 0; i < 100 && gq.size() < 4; i++) step(1);
    chk("t4_grant_cnt", (gq.size() >= 4) ? 1 : 0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t4_grant_order", (gq.size() > i) ? gq[i] : 9, i % 2);
    end
    chk("t4_no_dual", dual, 0);
    req0_valid = 0; req1_valid = 0;
    step(12);

    // Reset while waiting in the read-data phase
    r_lat = 5;
    req0_valid = 1; req0_write = 0; req0_addr = 8'h20;
    step(1);
    chk("t5_ready0", req0_ready, 1);
    req0_valid = 0;
    step(2);
    chk("t5_in_rd_r", rready, 1);
    step(1);
    base0 = r0cnt; base1 = r1cnt;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ctrl", {awvalid, wvalid, bready, arvalid, rready, req0_ready, req1_ready,
                        resp0_valid, resp1_valid}, 64'h0);
    chk("t5_rst_addr", {awaddr, araddr, wstrb, resp0_resp, resp1_resp}, 64'h0);
    step(2);
    rst_n = 1'b1;
    r_lat = 0;
    step(10);
    chk("t5_no_resp", (r0cnt - base0) + (r1cnt - base1), 0);
    chk("t5_idle_after", {rready, arvalid}, 0);
    b_resp = 3'b001;
    req1_valid = 1; req1_write = 1; req1_addr = 8'h30; req1_wdata = 32'hAB; req1_wstrb = 4'hF;
    step(1);
    chk("t5_ready1", req1_ready, 1);
    req1_valid = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (resp1_valid) found = 1;
    end
    chk("t5_resp_seen", found, 1);
    chk("t5_resp_code", resp1_resp, 3'b001);
    chk("t5_resp_rdata", resp1_rdata, 0);
    step(3);

    // Requester 0 drops valid while the arbiter is in GRANT
    r_data = 32'h5A5A; r_resp = 3'b001;
    base0 = r0cnt;
    req0_valid = 1; req0_write = 0; req0_addr = 8'h04;
    step(1);
    chk("t6_ready0", req0_ready, 1);
    req0_valid = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (resp0_valid) found = 1;
    end
    chk("t6_resp_seen", found, 1);
    chk("t6_rdata", resp0_rdata, 32'h5A5A);
    chk("t6_rresp", resp0_resp, 3'b001);
    step(3);
    chk("t6_pulse_count", r0cnt - base0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
